// File: rtl/sonar_scan_ctrl.sv
// Round-robin ultrasonic scanner: fires each channel's trigger, times its echo with
// a timeout, compares the width to a threshold and sends a header+width frame to a UART.
module sonar_scan_ctrl #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 24,
    parameter int TRIG_CYC    = 1000,
    parameter int TIMEOUT_CYC = 3_800_000,
    parameter int GAP_CYC     = 6_000_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] thresh_i,
    input  logic [N_CH-1:0]  echo_i,
    output logic [N_CH-1:0]  trig_o,
    input  logic             tx_busy_i,
    output logic [7:0]       tx_byte_o,
    output logic             tx_start_o,
    output logic [N_CH-1:0]  near_o,
    output logic             busy_o,
    output logic             scan_done_o
);

    localparam int               NB       = CNT_W / 8;
    localparam logic [3:0]       LAST_CH  = 4'(N_CH - 1);
    localparam logic [7:0]       LAST_IDX = 8'(NB);
    localparam logic [31:0]      TRIG_END = 32'(TRIG_CYC - 1);
    localparam logic [31:0]      GAP_END  = 32'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] TO_END   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_SAT   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ch_q, ch_d;
    logic [31:0]      tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             timeout_q, timeout_d;
    logic [7:0]       idx_q, idx_d;
    logic [1:0]       holdoff_q, holdoff_d;
    logic [N_CH-1:0]  echo_meta_q, echo_sync_q;
    logic             echo_prev_q;
    logic [N_CH-1:0]  trig_q, trig_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic             tx_start_q, tx_start_d;
    logic [N_CH-1:0]  near_q, near_d;
    logic             busy_q, busy_d;
    logic             scan_done_q, scan_done_d;

    logic [N_CH-1:0]  ch_oh_s;
    logic             echo_cur_s;
    logic             near_cur_s;
    logic             near_new_s;
    logic             enter_send_s;
    logic [7:0]       header_s;

    // Byte idx of the frame: 0 is the header, 1..NB are the width bytes MSB first.
    function automatic logic [7:0] frame_byte(input logic [7:0]       idx,
                                              input logic [CNT_W-1:0] width,
                                              input logic [7:0]       header);
        frame_byte = header;
        for (int k = 0; k < NB; k++) begin
            if (idx == 8'(k + 1)) begin
                frame_byte = width[CNT_W-1-8*k -: 8];
            end else begin
                frame_byte = frame_byte;
            end
        end
    endfunction

    // One-hot decode of the active channel, used to pick its echo and near bit.
    always_comb begin
        ch_oh_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            ch_oh_s[i] = (ch_q == 4'(i));
        end
    end

    assign echo_cur_s = |(echo_sync_q & ch_oh_s);
    assign near_cur_s = |(near_q & ch_oh_s);
    assign header_s   = {2'b10, timeout_q, near_cur_s, ch_q};

    // Next-state and registered-output logic for the scan sequencer.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        tmr_d        = tmr_q;
        cnt_d        = cnt_q;
        width_d      = width_q;
        timeout_d    = timeout_q;
        idx_d        = idx_q;
        holdoff_d    = (holdoff_q != 2'd0) ? (holdoff_q - 2'd1) : 2'd0;
        tx_byte_d    = tx_byte_q;
        tx_start_d   = 1'b0;
        scan_done_d  = 1'b0;
        enter_send_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i || en_i) begin
                    state_d = ST_TRIG;
                    ch_d    = 4'd0;
                    tmr_d   = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRIG: begin
                if (tmr_q >= TRIG_END) begin
                    state_d   = ST_WAIT_RISE;
                    tmr_d     = 32'd0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            ST_WAIT_RISE: begin
                // The rising cycle itself is the first high cycle of the pulse.
                if (echo_cur_s && !echo_prev_q) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= TO_END) begin
                    state_d      = ST_SEND;
                    cnt_d        = TO_SAT;
                    timeout_d    = 1'b1;
                    width_d      = '1;
                    enter_send_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (!echo_cur_s) begin
                    state_d      = ST_SEND;
                    timeout_d    = 1'b0;
                    width_d      = cnt_q;
                    enter_send_s = 1'b1;
                end else if (cnt_q >= TO_END) begin
                    state_d      = ST_SEND;
                    cnt_d        = TO_SAT;
                    timeout_d    = 1'b1;
                    width_d      = '1;
                    enter_send_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SEND: begin
                // Holdoff spans the cycles before the UART's busy flag becomes visible.
                if (!tx_busy_i && (holdoff_q == 2'd0)) begin
                    tx_start_d = 1'b1;
                    tx_byte_d  = frame_byte(idx_q, width_q, header_s);
                    holdoff_d  = 2'd2;
                    if (idx_q >= LAST_IDX) begin
                        state_d = ST_GAP;
                        tmr_d   = 32'd0;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (tmr_q >= GAP_END) begin
                    tmr_d = 32'd0;
                    if (ch_q >= LAST_CH) begin
                        scan_done_d = 1'b1;
                        ch_d        = 4'd0;
                        state_d     = en_i ? ST_TRIG : ST_IDLE;
                    end else begin
                        ch_d    = ch_q + 4'd1;
                        state_d = ST_TRIG;
                    end
                end else begin
                    tmr_d = tmr_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        near_new_s = !timeout_d && (width_d < thresh_i);
        for (int i = 0; i < N_CH; i++) begin
            near_d[i] = (enter_send_s && ch_oh_s[i]) ? near_new_s : near_q[i];
            trig_d[i] = (state_d == ST_TRIG) && (ch_d == 4'(i));
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, echo synchroniser and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ch_q        <= 4'd0;
            tmr_q       <= 32'd0;
            cnt_q       <= '0;
            width_q     <= '0;
            timeout_q   <= 1'b0;
            idx_q       <= 8'd0;
            holdoff_q   <= 2'd0;
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            echo_prev_q <= 1'b0;
            trig_q      <= '0;
            tx_byte_q   <= 8'd0;
            tx_start_q  <= 1'b0;
            near_q      <= '0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            tmr_q       <= tmr_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            timeout_q   <= timeout_d;
            idx_q       <= idx_d;
            holdoff_q   <= holdoff_d;
            echo_meta_q <= echo_i;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_cur_s;
            trig_q      <= trig_d;
            tx_byte_q   <= tx_byte_d;
            tx_start_q  <= tx_start_d;
            near_q      <= near_d;
            busy_q      <= busy_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign trig_o      = trig_q;
    assign tx_byte_o   = tx_byte_q;
    assign tx_start_o  = tx_start_q;
    assign near_o      = near_q;
    assign busy_o      = busy_q;
    assign scan_done_o = scan_done_q;

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Randomised bench for sonar_scan_ctrl: echo drivers follow per-channel plans and the
// expected frames, trigger sequence and near flags are derived from those plans.
module tb_sonar_scan_ctrl;

    localparam int N_CH        = 2;
    localparam int CNT_W       = 16;
    localparam int TRIG_CYC    = 4;
    localparam int TIMEOUT_CYC = 1000;
    localparam int GAP_CYC     = 8;

    logic              clk     = 1'b0;
    logic              rst     = 1'b1;
    logic              en      = 1'b0;
    logic              start   = 1'b0;
    logic              tx_busy = 1'b0;
    logic [CNT_W-1:0]  thresh  = '0;
    wire  [N_CH-1:0]   echo;
    logic [N_CH-1:0]   trig;
    logic [7:0]        tx_byte;
    logic              tx_start;
    logic [N_CH-1:0]   near;
    logic              busy;
    logic              scan_done;

    sonar_scan_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYC(TRIG_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start), .thresh_i(thresh),
        .echo_i(echo), .trig_o(trig), .tx_busy_i(tx_busy), .tx_byte_o(tx_byte),
        .tx_start_o(tx_start), .near_o(near), .busy_o(busy), .scan_done_o(scan_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Echo plan per channel: mode 0 none, 1 pulse after delay, 2 high before trigger
    int plan_mode [N_CH];
    int plan_pre  [N_CH];
    int plan_dly  [N_CH];
    int plan_w    [N_CH];
    int busy_len = 0;

    logic [7:0]      got_q[$];
    logic [7:0]      exp_q[$];
    int              trig_ch_q[$];
    int              trig_len_q[$];
    int              exp_trig_q[$];
    logic [N_CH-1:0] near_model = '0;
    int done_cnt = 0, overrun_cnt = 0, onehot_err = 0, dup_cnt = 0;
    int run_len[N_CH];
    int busy_cnt = 0;
    logic prev_start = 1'b0;

    // Observer plus UART busy model, sampled on the falling edge
    always @(negedge clk) begin
        if (tx_start) begin
            got_q.push_back(tx_byte);
            if (tx_busy) overrun_cnt++;
            if (prev_start) dup_cnt++;
        end
        prev_start = tx_start;
        if (scan_done) done_cnt++;
        if ($countones(trig) > 1) onehot_err++;
        for (int i = 0; i < N_CH; i++) begin
            if (trig[i]) run_len[i]++;
            else if (run_len[i] != 0) begin
                trig_ch_q.push_back(i);
                trig_len_q.push_back(run_len[i]);
                run_len[i] = 0;
            end
        end
        if (tx_start && busy_len > 0) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt > 0);
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_drv
        logic e_r = 1'b0;
        assign echo[g] = e_r;
        initial begin
            forever begin
                @(posedge trig[g]);
                @(negedge clk);
                if (plan_mode[g] == 2) e_r = 1'b1;
                @(negedge trig[g]);
                @(negedge clk);
                if (plan_mode[g] == 2) begin
                    repeat (plan_pre[g]) @(negedge clk);
                    e_r = 1'b0;
                end
                if (plan_mode[g] != 0) begin
                    repeat (plan_dly[g]) @(negedge clk);
                    e_r = 1'b1;
                    repeat (plan_w[g]) @(negedge clk);
                    e_r = 1'b0;
                end
            end
        end
    end

    task automatic clear_queues();
        got_q.delete(); exp_q.delete();
        trig_ch_q.delete(); trig_len_q.delete(); exp_trig_q.delete();
    endtask

    // Expected frame for one channel pass, straight from the measurement rules
    task automatic build_expected(input logic [CNT_W-1:0] thr);
        for (int c = 0; c < N_CH; c++) begin
            bit          to;
            bit          nr;
            logic [15:0] wv;
            logic [3:0]  cv;
            to = (plan_mode[c] == 0) || (plan_w[c] >= TIMEOUT_CYC);
            nr = !to && (plan_w[c] < int'(thr));
            wv = to ? 16'hFFFF : 16'(plan_w[c]);
            cv = 4'(c);
            near_model[c] = nr;
            exp_q.push_back({2'b10, to, nr, cv});
            exp_q.push_back(wv[15:8]);
            exp_q.push_back(wv[7:0]);
            exp_trig_q.push_back(c);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ":scan_done_seen"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_echo_idle();
        int n = 0;
        while (echo !== '0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        check_eq("echo_idle", 32'(echo), 32'd0);
    endtask

    task automatic compare_scan(input string tag);
        check_eq({tag, ":nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s:byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        check_eq({tag, ":ntrig"}, trig_ch_q.size(), exp_trig_q.size());
        for (int i = 0; i < exp_trig_q.size() && i < trig_ch_q.size(); i++) begin
            check_eq($sformatf("%s:trig_ch%0d", tag, i), trig_ch_q[i], exp_trig_q[i]);
            check_eq($sformatf("%s:trig_len%0d", tag, i), trig_len_q[i], TRIG_CYC);
        end
        check_eq({tag, ":near"}, 32'(near), 32'(near_model));
        check_eq({tag, ":busy_after"}, 32'(busy), 32'd0);
        clear_queues();
    endtask

    task automatic run_scan(input string tag, input logic [CNT_W-1:0] thr, input bit extra_start);
        int base;
        clear_queues();
        thresh = thr;
        build_expected(thr);
        base = done_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        if (extra_start) begin
            repeat (60) @(negedge clk);
            start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        wait_done(base + 1, 9000, tag);
        repeat (20) @(negedge clk);
        check_eq({tag, ":done_pulses"}, done_cnt - base, 1);
        compare_scan(tag);
        wait_echo_idle();
    endtask

    task automatic set_plan(input int c, input int mode, input int pre, input int dly, input int w);
        plan_mode[c] = mode; plan_pre[c] = pre; plan_dly[c] = dly; plan_w[c] = w;
    endtask

    initial begin
        int base;
        int n;
        for (int c = 0; c < N_CH; c++) set_plan(c, 0, 0, 0, 1);

        repeat (4) @(negedge clk);
        check_eq("rst:trig", 32'(trig), 32'd0);
        check_eq("rst:busy", 32'(busy), 32'd0);
        check_eq("rst:near", 32'(near), 32'd0);
        check_eq("rst:tx_start", 32'(tx_start), 32'd0);
        check_eq("rst:tx_byte", 32'(tx_byte), 32'd0);
        check_eq("rst:scan_done", 32'(scan_done), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Directed: 300-cycle echo on ch0, silent ch1, extra start mid-scan ignored
        busy_len = 0;
        set_plan(0, 1, 0, 20, 300);
        set_plan(1, 0, 0, 0, 1);
        run_scan("scanA", 16'd500, 1'b1);

        // Echo timeout on ch0; ch1 width equal to threshold is not near
        set_plan(0, 1, 0, 5, 1200);
        set_plan(1, 1, 0, 30, 999);
        run_scan("scanB", 16'd999, 1'b0);

        // Echo high at trigger time, width one below threshold; UART busy 50 cycles
        busy_len = 50;
        set_plan(0, 2, 30, 40, 120);
        set_plan(1, 1, 0, 0, 1);
        run_scan("scanC", 16'd121, 1'b0);

        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < N_CH; c++) begin
                int r;
                r = $urandom_range(0, 7);
                if (r == 0) set_plan(c, 0, 0, 0, 1);
                else if (r == 1) set_plan(c, 2, $urandom_range(0, 100), $urandom_range(1, 200), $urandom_range(1, 600));
                else if (r == 2) set_plan(c, 1, 0, $urandom_range(0, 200), $urandom_range(1000, 1300));
                else set_plan(c, 1, 0, $urandom_range(0, 300), $urandom_range(1, 900));
            end
            case ($urandom_range(0, 2))
                0: busy_len = 0;
                1: busy_len = 50;
                default: busy_len = $urandom_range(1, 20);
            endcase
            run_scan($sformatf("rnd%0d", s), 16'($urandom_range(1, 1000)), 1'b0);
        end

        // Continuous mode: two full scans, en dropped during ch0 of the third
        busy_len = 0;
        set_plan(0, 1, 0, 10, 200);
        set_plan(1, 1, 0, 15, 400);
        clear_queues();
        thresh = 16'd1000;
        for (int k = 0; k < 3; k++) build_expected(16'd1000);
        base = done_cnt;
        @(negedge clk) en = 1'b1;
        wait_done(base + 2, 12000, "cont2");
        en = 1'b0;
        check_eq("cont:trig0_after_scan2", 32'(trig[0]), 32'd1);
        wait_done(base + 3, 6000, "cont3");
        repeat (60) @(negedge clk);
        check_eq("cont:done_pulses", done_cnt - base, 3);
        compare_scan("cont");
        wait_echo_idle();

        // Reset while measuring ch0
        set_plan(0, 1, 0, 10, 300);
        set_plan(1, 0, 0, 0, 1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (echo[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        check_eq("rstm:busy_before", 32'(busy), 32'd1);
        check_eq("rstm:near_before", 32'(near), 32'h3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstm:trig", 32'(trig), 32'd0);
        check_eq("rstm:near", 32'(near), 32'd0);
        check_eq("rstm:busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_echo_idle();

        // Reset while a trigger is high
        set_plan(0, 0, 0, 0, 1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (trig[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("rstt:trig_before", 32'(trig), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstt:trig", 32'(trig), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Fresh scan after reset
        near_model = '0;
        set_plan(0, 1, 0, 20, 300);
        set_plan(1, 0, 0, 0, 1);
        run_scan("fresh", 16'd500, 1'b0);

        check_eq("trig_onehot_err", onehot_err, 0);
        check_eq("tx_overrun", overrun_cnt, 0);
        check_eq("tx_start_dup", dup_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
